wr_time_counter: RTL

Local White Rabbit time-of-day counter driven by the timing interface (`tm_tai`, `tm_tai_valid`, `pps_in`). It keeps a free-running seconds/nanoseconds count in `clk_sys`, aligns it to the incoming PPS, and qualifies lock after repeated in-phase pulses. It publishes `cntr_utc`, `cntr_nsec` and `cntr_valid`, and regenerates a clean `pps_out`. It sits between the WR timing source and all timestamping/monitor logic.

---
 rtl/wr_timing_pkg.sv | 14 +
 rtl/wr_pps_pulse_gen.sv | 34 +++
 rtl/wr_time_counter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/wr_timing_pkg.sv
// rtl/wr_timing_pkg.sv - shared lock-state type and default timing constants for the WR time counter
package wr_timing_pkg;

    typedef enum logic [1:0] {
        ST_UNSYNC   = 2'd0,
        ST_ALIGN    = 2'd1,
        ST_LOCKED   = 2'd2,
        ST_HOLDOVER = 2'd3
    } wr_lock_state_t;

    localparam int unsigned WR_CLK_PERIOD_NS = 8;
    localparam int unsigned WR_NS_PER_SEC    = 1_000_000_000;

endpackage

// File: rtl/wr_pps_pulse_gen.sv
// rtl/wr_pps_pulse_gen.sv - non-retriggerable pulse stretcher for the regenerated PPS
module wr_pps_pulse_gen #(
    parameter int unsigned WIDTH_CYCLES = 4
) (
    input  logic clk_sys,
    input  logic rst,
    input  logic start,
    output logic pulse
);

    localparam int unsigned CNT_W = (WIDTH_CYCLES > 1) ? $clog2(WIDTH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] remaining;

    // start is only honoured while idle, so a running pulse always completes unchanged
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            pulse     <= 1'b0;
            remaining <= '0;
        end else if (pulse) begin
            if (remaining == '0) begin
                pulse <= 1'b0;
            end else begin
                remaining <= remaining - CNT_ONE;
            end
        end else if (start) begin
            pulse     <= 1'b1;
            remaining <= CNT_LOAD;
        end
    end

endmodule

// File: rtl/wr_time_counter.sv
// rtl/wr_time_counter.sv - PPS-aligned seconds/nanoseconds counter with lock qualification
// Optional holdover state is built when WR_TIME_COUNTER_HOLDOVER_EN is defined.
module wr_time_counter
    import wr_timing_pkg::*;
#(
    parameter int unsigned CLK_PERIOD_NS    = WR_CLK_PERIOD_NS,
    parameter int unsigned NS_PER_SEC       = WR_NS_PER_SEC,
    parameter int unsigned LOCK_COUNT       = 3,
    parameter int unsigned PPS_WIDTH_CYCLES = 4,
    parameter int unsigned HOLDOVER_SECS    = 8
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        pps_in,
    input  logic [63:0] tm_tai,
    input  logic        tm_tai_valid,
    output logic [31:0] cntr_nsec,
    output logic [39:0] cntr_utc,
    output logic        cntr_valid,
    output logic        pps_out,
    output logic        sync_err,
    output logic [1:0]  lock_state
);

    localparam logic [31:0] NS_STEP = 32'(CLK_PERIOD_NS);
    localparam logic [31:0] WRAP_NS = 32'(NS_PER_SEC - CLK_PERIOD_NS);
    localparam int unsigned GOOD_W  = $clog2(LOCK_COUNT + 1);
    localparam logic [GOOD_W-1:0] GOOD_ONE  = GOOD_W'(1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);

    wr_lock_state_t    state, state_n;
    logic              pps_in_d;
    logic              pps_rise, wrap, in_phase;
    logic [31:0]       nsec_n;
    logic [39:0]       utc_n, tai_sec;
    logic [GOOD_W-1:0] good, good_n;
    logic              sync_err_n;
    logic              unused_tai;

    assign tai_sec    = tm_tai[39:0];
    assign unused_tai = ^tm_tai[63:40];
    assign pps_rise   = pps_in & ~pps_in_d;
    assign wrap       = (cntr_nsec == WRAP_NS);
    assign in_phase   = pps_rise & wrap;
    assign lock_state = state;

`ifdef WR_TIME_COUNTER_HOLDOVER_EN
    localparam int unsigned MISS_W = $clog2(HOLDOVER_SECS + 1);
    localparam logic [MISS_W-1:0] MISS_ONE  = MISS_W'(1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(HOLDOVER_SECS - 1);
    logic [MISS_W-1:0] miss, miss_n;

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            miss <= '0;
        end else begin
            miss <= miss_n;
        end
    end
`else
    logic unused_holdover;
    assign unused_holdover = ^32'(HOLDOVER_SECS);
`endif

    always_comb begin
        state_n    = state;
        good_n     = good;
        sync_err_n = 1'b0;
`ifdef WR_TIME_COUNTER_HOLDOVER_EN
        miss_n     = miss;
`endif
        if (wrap) begin
            nsec_n = '0;
            utc_n  = cntr_utc + 40'd1;
        end else begin
            nsec_n = cntr_nsec + NS_STEP;
            utc_n  = cntr_utc;
        end

        if (!tm_tai_valid) begin
            state_n = ST_UNSYNC;
            good_n  = '0;
`ifdef WR_TIME_COUNTER_HOLDOVER_EN
            miss_n  = '0;
`endif
        end else begin
            case (state)
                ST_UNSYNC: begin
                    if (pps_rise) begin
                        nsec_n  = '0;
                        utc_n   = tai_sec;
                        good_n  = GOOD_ONE;
                        state_n = ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
                    if (in_phase) begin
                        utc_n  = tai_sec;
                        good_n = good + GOOD_ONE;
                        if (good == GOOD_LAST) begin
                            state_n = ST_LOCKED;
                        end
                    end else if (pps_rise) begin
                        sync_err_n = 1'b1;
                        nsec_n     = '0;
                        utc_n      = tai_sec;
                        good_n     = GOOD_ONE;
                    end else if (wrap) begin
                        state_n = ST_UNSYNC;
                        good_n  = '0;
                    end
                end
                ST_LOCKED: begin
                    if (in_phase) begin
                        sync_err_n = (tai_sec != utc_n);
                        utc_n      = tai_sec;
                    end else if (pps_rise) begin
                        sync_err_n = 1'b1;
                        nsec_n     = '0;
                        utc_n      = tai_sec;
                        good_n     = GOOD_ONE;
                        state_n    = ST_ALIGN;
                    end else if (wrap) begin
`ifdef WR_TIME_COUNTER_HOLDOVER_EN
                        miss_n  = MISS_ONE;
                        state_n = ST_HOLDOVER;
`else
                        good_n  = '0;
                        state_n = ST_UNSYNC;
`endif
                    end
                end
`ifdef WR_TIME_COUNTER_HOLDOVER_EN
                ST_HOLDOVER: begin
                    if (in_phase) begin
                        miss_n  = '0;
                        state_n = ST_LOCKED;
                    end else if (pps_rise) begin
                        sync_err_n = 1'b1;
                        nsec_n     = '0;
                        utc_n      = tai_sec;
                        good_n     = GOOD_ONE;
                        miss_n     = '0;
                        state_n    = ST_ALIGN;
                    end else if (wrap) begin
                        if (miss == MISS_LAST) begin
                            miss_n  = '0;
                            good_n  = '0;
                            state_n = ST_UNSYNC;
                        end else begin
                            miss_n = miss + MISS_ONE;
                        end
                    end
                end
`endif
                default: begin
                    good_n  = '0;
                    state_n = ST_UNSYNC;
                end
            endcase
        end
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            pps_in_d   <= 1'b0;
            cntr_nsec  <= '0;
            cntr_utc   <= '0;
            state      <= ST_UNSYNC;
            good       <= '0;
            sync_err   <= 1'b0;
            cntr_valid <= 1'b0;
        end else begin
            pps_in_d   <= pps_in;
            cntr_nsec  <= nsec_n;
            cntr_utc   <= utc_n;
            state      <= state_n;
            good       <= good_n;
            sync_err   <= sync_err_n;
            cntr_valid <= (state_n == ST_LOCKED) || (state_n == ST_HOLDOVER);
        end
    end

    // pulse begins on the edge where cntr_nsec returns to 0
    wr_pps_pulse_gen #(
        .WIDTH_CYCLES(PPS_WIDTH_CYCLES)
    ) u_pps_gen (
        .clk_sys(clk_sys),
        .rst    (rst),
        .start  (wrap & cntr_valid),
        .pulse  (pps_out)
    );

endmodule
